// File: rtl/uart_cmd_pkg.sv
// ASCII command codes shared by the UART command decoder and the echo/transmit path.
package uart_cmd_pkg;

    localparam logic [7:0] ASCII_R = 8'h72;
    localparam logic [7:0] ASCII_L = 8'h6C;
    localparam logic [7:0] ASCII_U = 8'h75;
    localparam logic [7:0] ASCII_D = 8'h64;
    localparam logic [7:0] ASCII_0 = 8'h30;
    localparam logic [7:0] ASCII_1 = 8'h31;
    localparam logic [7:0] ASCII_2 = 8'h32;

endpackage

// File: rtl/ascii_decoder.sv
// Turns received UART bytes into one-cycle virtual button pulses and toggled virtual switch levels.
module ascii_decoder
    import uart_cmd_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_done,
    output logic       uart_btn_r,
    output logic       uart_btn_l,
    output logic       uart_btn_u,
    output logic       uart_btn_d,
    output logic       uart_sw_mode,
    output logic       uart_sw_sel_mode,
    output logic       uart_sw_sel_display
);

    // Buttons fall back to 0 every cycle, so a held rx_done re-pulses each cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            uart_btn_r <= 1'b0;
            uart_btn_l <= 1'b0;
            uart_btn_u <= 1'b0;
            uart_btn_d <= 1'b0;
        end else begin
            uart_btn_r <= 1'b0;
            uart_btn_l <= 1'b0;
            uart_btn_u <= 1'b0;
            uart_btn_d <= 1'b0;
            if (rx_done) begin
                case (rx_data)
                    ASCII_R: uart_btn_r <= 1'b1;
                    ASCII_L: uart_btn_l <= 1'b1;
                    ASCII_U: uart_btn_u <= 1'b1;
                    ASCII_D: uart_btn_d <= 1'b1;
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            uart_sw_mode        <= 1'b0;
            uart_sw_sel_mode    <= 1'b0;
            uart_sw_sel_display <= 1'b0;
        end else if (rx_done) begin
            case (rx_data)
                ASCII_0: uart_sw_mode        <= ~uart_sw_mode;
                ASCII_1: uart_sw_sel_mode    <= ~uart_sw_sel_mode;
                ASCII_2: uart_sw_sel_display <= ~uart_sw_sel_display;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ascii_decoder.sv
// Scoreboard bench for ascii_decoder: expected output vectors are queued as bytes are driven.
module tb_ascii_decoder;

    logic       clk;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       uart_btn_r;
    logic       uart_btn_l;
    logic       uart_btn_u;
    logic       uart_btn_d;
    logic       uart_sw_mode;
    logic       uart_sw_sel_mode;
    logic       uart_sw_sel_display;

    int total = 0;
    int bad   = 0;

    logic [6:0] sb_q[$];
    logic [2:0] exp_sw;

    ascii_decoder dut (
        .clk                 (clk),
        .rst                 (rst),
        .rx_data             (rx_data),
        .rx_done             (rx_done),
        .uart_btn_r          (uart_btn_r),
        .uart_btn_l          (uart_btn_l),
        .uart_btn_u          (uart_btn_u),
        .uart_btn_d          (uart_btn_d),
        .uart_sw_mode        (uart_sw_mode),
        .uart_sw_sel_mode    (uart_sw_sel_mode),
        .uart_sw_sel_display (uart_sw_sel_display)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] observed();
        return {uart_btn_r, uart_btn_l, uart_btn_u, uart_btn_d,
                uart_sw_mode, uart_sw_sel_mode, uart_sw_sel_display};
    endfunction

    // Drive one cycle of stimulus, queue what the outputs must be after the edge.
    task automatic step(input logic [7:0] d, input logic v);
        logic [3:0] btn;
        rx_data = d;
        rx_done = v;
        btn = 4'b0000;
        if (v) begin
            case (d)
                8'h72: btn = 4'b1000;
                8'h6C: btn = 4'b0100;
                8'h75: btn = 4'b0010;
                8'h64: btn = 4'b0001;
                8'h30: exp_sw = exp_sw ^ 3'b100;
                8'h31: exp_sw = exp_sw ^ 3'b010;
                8'h32: exp_sw = exp_sw ^ 3'b001;
                default: ;
            endcase
        end
        sb_q.push_back({btn, exp_sw});
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [6:0] exp;
        rst     = 1'b1;
        rx_data = 8'h72;
        rx_done = 1'b0;
        exp_sw  = 3'b000;
        #20;
        total++;
        if (observed() !== 7'b0) begin
            bad++;
            $display("FAIL reset_hold got=%b want=%b", observed(), 7'b0);
        end
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step(8'h72, 1'b0);
            exp = sb_q.pop_front();
            total++;
            if (observed() !== exp) begin
                bad++;
                $display("FAIL reset_idle[%0d] got=%b want=%b", i, observed(), exp);
            end
        end
    endtask

    task automatic test_buttons();
        logic [7:0] seq_d[6] = '{8'h72, 8'h00, 8'h00, 8'h6C, 8'h00, 8'h00};
        logic       seq_v[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [6:0] exp;
        for (int i = 0; i < 6; i++) begin
            step(seq_d[i], seq_v[i]);
            exp = sb_q.pop_front();
            total++;
            if (observed() !== exp) begin
                bad++;
                $display("FAIL buttons[%0d] got=%b want=%b", i, observed(), exp);
            end
        end
    endtask

    task automatic test_switch_mode();
        logic [7:0] seq_d[4] = '{8'h30, 8'h00, 8'h30, 8'h00};
        logic       seq_v[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic [6:0] exp;
        for (int i = 0; i < 4; i++) begin
            step(seq_d[i], seq_v[i]);
            exp = sb_q.pop_front();
            total++;
            if (observed() !== exp) begin
                bad++;
                $display("FAIL sw_mode[%0d] got=%b want=%b", i, observed(), exp);
            end
        end
    endtask

    task automatic test_select_switches();
        logic [7:0] seq_d[3] = '{8'h31, 8'h32, 8'h00};
        logic       seq_v[3] = '{1'b1, 1'b1, 1'b0};
        logic [6:0] exp;
        for (int i = 0; i < 3; i++) begin
            step(seq_d[i], seq_v[i]);
            exp = sb_q.pop_front();
            total++;
            if (observed() !== exp) begin
                bad++;
                $display("FAIL sel_sw[%0d] got=%b want=%b", i, observed(), exp);
            end
        end
    endtask

    task automatic test_unrecognised();
        logic [7:0] seq_d[6] = '{8'h52, 8'h78, 8'h00, 8'h72, 8'h4C, 8'h33};
        logic       seq_v[6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        logic [6:0] exp;
        for (int i = 0; i < 6; i++) begin
            step(seq_d[i], seq_v[i]);
            exp = sb_q.pop_front();
            total++;
            if (observed() !== exp) begin
                bad++;
                $display("FAIL ignored[%0d] got=%b want=%b", i, observed(), exp);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] seq_d[8] = '{8'h72, 8'h72, 8'h30, 8'h30, 8'h75, 8'h64, 8'h32, 8'h00};
        logic       seq_v[8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [6:0] exp;
        for (int i = 0; i < 8; i++) begin
            step(seq_d[i], seq_v[i]);
            exp = sb_q.pop_front();
            total++;
            if (observed() !== exp) begin
                bad++;
                $display("FAIL back_to_back[%0d] got=%b want=%b", i, observed(), exp);
            end
        end
    endtask

    task automatic test_reset_mid_pulse();
        logic [7:0] seq_d[2] = '{8'h30, 8'h75};
        logic [7:0] post_d[3] = '{8'h64, 8'h00, 8'h00};
        logic       post_v[3] = '{1'b1, 1'b0, 1'b0};
        logic [6:0] exp;
        for (int i = 0; i < 2; i++) begin
            step(seq_d[i], 1'b1);
            exp = sb_q.pop_front();
            total++;
            if (observed() !== exp) begin
                bad++;
                $display("FAIL pre_reset[%0d] got=%b want=%b", i, observed(), exp);
            end
        end
        // Assert reset mid-cycle while btn_u is high; outputs must clear without a clock edge.
        rx_done = 1'b0;
        rst     = 1'b1;
        #1;
        total++;
        if ({uart_btn_u, uart_sw_mode} !== 2'b00 || observed() !== 7'b0) begin
            bad++;
            $display("FAIL async_reset got=%b want=%b", observed(), 7'b0);
        end
        rx_data = 8'h31;
        rx_done = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (observed() !== 7'b0) begin
            bad++;
            $display("FAIL reset_dominates got=%b want=%b", observed(), 7'b0);
        end
        rx_done = 1'b0;
        rst     = 1'b0;
        exp_sw  = 3'b000;
        for (int i = 0; i < 3; i++) begin
            step(post_d[i], post_v[i]);
            exp = sb_q.pop_front();
            total++;
            if (observed() !== exp) begin
                bad++;
                $display("FAIL post_reset[%0d] got=%b want=%b", i, observed(), exp);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_buttons();
        test_switch_mode();
        test_select_switches();
        test_unrecognised();
        test_back_to_back();
        test_reset_mid_pulse();
        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain got=%0d want=0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
